hazard_tracker: RTL

HAZARD_TRACKER -- requirements
Module: hazard_tracker

---
 rtl/hazard_tracker.sv | 110 +++++++++++
 1 files changed

// File: rtl/hazard_tracker.sv
// Hazard tracker for a five-stage pipeline. Keeps a small shadow of the
// EX and MEM stage destinations, resolves operand forwarding for the ID
// instruction, and raises a one-cycle bubble on load-use dependencies.
// A load feeding only the data operand of a store is not stalled. The
// store takes the load data late, through forward_ctrl_ls.
module hazard_tracker (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid,
   input  logic [4:0] rs1_id,
   input  logic [4:0] rs2_id,
   input  logic [4:0] rd_id,
   input  logic       rs1use,
   input  logic       rs2use,
   input  logic [1:0] hazard_optype,
   input  logic       Branch,
   output logic [1:0] forward_ctrl_A,
   output logic [1:0] forward_ctrl_B,
   output logic       forward_ctrl_ls,
   output logic       PC_EN_IF,
   output logic       reg_FD_EN,
   output logic       reg_FD_flush,
   output logic       reg_DE_flush
);

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_ALU   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_STORE = 2'b11;

   localparam logic [1:0] SEL_RF      = 2'b00;
   localparam logic [1:0] SEL_EX_ALU  = 2'b01;
   localparam logic [1:0] SEL_MEM_ALU = 2'b10;
   localparam logic [1:0] SEL_MEM_LD  = 2'b11;

   logic [4:0] ex_rd, mem_rd;
   logic [1:0] ex_op, mem_op;
   logic       ls_q;

   logic       ex_prod, mem_prod;
   logic       use1, use2;
   logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2;
   logic       ld_hit1, ld_hit2;
   logic       store_exc;
   logic       stall;

   // Shadow pipeline: ID instruction moves into EX unless stalled or a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rd  <= 5'd0;
         ex_op  <= OP_NONE;
         mem_rd <= 5'd0;
         mem_op <= OP_NONE;
         ls_q   <= 1'b0;
      end else begin
         mem_rd <= ex_rd;
         mem_op <= ex_op;
         if (id_valid && !stall) begin
            ex_rd <= rd_id;
            ex_op <= hazard_optype;
         end else begin
            ex_rd <= 5'd0;
            ex_op <= OP_NONE;
         end
         ls_q <= store_exc;
      end
   end

   // Source matching, forward selection and the stall decision.
   always_comb begin
      ex_prod  = (ex_rd != 5'd0) && ((ex_op == OP_ALU) || (ex_op == OP_LOAD));
      mem_prod = (mem_rd != 5'd0) && ((mem_op == OP_ALU) || (mem_op == OP_LOAD));
      use1     = id_valid && rs1use && (rs1_id != 5'd0);
      use2     = id_valid && rs2use && (rs2_id != 5'd0);
      ex_hit1  = use1 && ex_prod && (rs1_id == ex_rd);
      ex_hit2  = use2 && ex_prod && (rs2_id == ex_rd);
      mem_hit1 = use1 && mem_prod && (rs1_id == mem_rd);
      mem_hit2 = use2 && mem_prod && (rs2_id == mem_rd);
      ld_hit1  = ex_hit1 && (ex_op == OP_LOAD);
      ld_hit2  = ex_hit2 && (ex_op == OP_LOAD);

      // Store data can pick up the load result one stage later.
      store_exc = ld_hit2 && !ld_hit1 && (hazard_optype == OP_STORE);
      stall     = (ld_hit1 || ld_hit2) && !store_exc;

      // An EX load hit leaves the select at regfile: either we stall or the
      // store picks the data up in MEM.
      forward_ctrl_A = SEL_RF;
      if (ex_hit1) begin
         if (ex_op == OP_ALU) forward_ctrl_A = SEL_EX_ALU;
      end else if (mem_hit1) begin
         forward_ctrl_A = (mem_op == OP_ALU) ? SEL_MEM_ALU : SEL_MEM_LD;
      end

      forward_ctrl_B = SEL_RF;
      if (ex_hit2) begin
         if (ex_op == OP_ALU) forward_ctrl_B = SEL_EX_ALU;
      end else if (mem_hit2) begin
         forward_ctrl_B = (mem_op == OP_ALU) ? SEL_MEM_ALU : SEL_MEM_LD;
      end

      forward_ctrl_ls = ls_q;
      PC_EN_IF        = !stall;
      reg_FD_EN       = !stall;
      reg_DE_flush    = stall;
      // Redirect inputs may still toggle during reset; keep the flush quiet.
      reg_FD_flush    = Branch && id_valid && !stall && rst_n;
   end

endmodule
